// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - request/response bundle between an alu_pipe requester and the alu_pipe core
interface alu_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with one-cycle ops and bit-serial shifts/rotates
// Defining ALU_PIPE_MUL_EN adds op 1101 as a WIDTH-cycle shift-add multiply.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
`ifdef ALU_PIPE_MUL_EN
  localparam int CW = SHW + 1;
`else
  localparam int CW = SHW;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, load_res, step_res;
  logic [CW-1:0]    cnt_q, start_cnt;
  logic [3:0]       op_q;
  logic [SHW-1:0]   amt;
  logic             accept, start_exec;
`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] mcand_q, mplier_q;
`endif

  assign amt           = bus.b[SHW-1:0];
  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = (res_q == '0);
  assign accept        = bus.in_valid && bus.in_ready;

  // Value loaded at accept: final result for one-cycle ops, seed for iterative ones.
  always_comb begin
    load_res   = '0;
    start_exec = 1'b0;
    start_cnt  = '0;
    case (bus.op)
      4'b0000: load_res = bus.a + bus.b;
      4'b0001: load_res = bus.a - bus.b;
      4'b0010: load_res = {WIDTH{bus.a >= bus.b}};
      4'b0011: load_res = {WIDTH{bus.a < bus.b}};
      4'b0100: load_res = {WIDTH{bus.a != bus.b}};
      4'b0101: load_res = {WIDTH{bus.a == bus.b}};
      4'b0110: load_res = bus.a & bus.b;
      4'b0111: load_res = bus.a | bus.b;
      4'b1000: load_res = bus.a ^ bus.b;
      4'b1001, 4'b1010, 4'b1011, 4'b1100: begin
        load_res   = bus.a;
        start_exec = (amt != '0);
        start_cnt  = CW'(amt);
      end
`ifdef ALU_PIPE_MUL_EN
      4'b1101: begin
        load_res   = '0;
        start_exec = 1'b1;
        start_cnt  = CW'(WIDTH);
      end
`endif
      default: load_res = '0;
    endcase
  end

  always_comb begin
    step_res = res_q;
    case (op_q)
      4'b1001: step_res = {res_q[WIDTH-2:0], res_q[WIDTH-1]};
      4'b1010: step_res = {res_q[0], res_q[WIDTH-1:1]};
      4'b1011: step_res = {res_q[WIDTH-2:0], 1'b0};
      4'b1100: step_res = {1'b0, res_q[WIDTH-1:1]};
`ifdef ALU_PIPE_MUL_EN
      4'b1101: step_res = mplier_q[0] ? (res_q + mcand_q) : res_q;
`endif
      default: step_res = res_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EXEC:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A DONE handshake with a new request overrides the return to IDLE.
    if (accept) state_d = start_exec ? EXEC : DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
`ifdef ALU_PIPE_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else if (accept) begin
      res_q    <= load_res;
      cnt_q    <= start_cnt;
      op_q     <= bus.op;
`ifdef ALU_PIPE_MUL_EN
      mcand_q  <= bus.a;
      mplier_q <= bus.b;
`endif
    end else if (state_q == EXEC) begin
      res_q    <= step_res;
      cnt_q    <= cnt_q - CW'(1);
`ifdef ALU_PIPE_MUL_EN
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
`endif
    end
  end
endmodule
